if_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 27 ++
 rtl/if_stage_if.sv | 30 +++
 rtl/fetch_skid_buf.sv | 47 ++++
 rtl/if_stage.sv | 152 +++++++++++++++
 tb/tb_if_stage.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the RISC-V pipeline front end.
//   XLEN          : datapath width
//   NOP_INSTR     : addi x0,x0,0, presented whenever a stage holds a bubble
//   fetch_state_t : instruction-fetch sequencer states
//   fetch_entry_t : {valid, instr, pc}, used by the IF/ID register and the
//                   fetch response buffer
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,  // free to issue a request
        WAIT  = 2'd1,  // one request outstanding, response wanted
        DRAIN = 2'd2   // one request outstanding, response to be dropped
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if
// Instruction-memory fetch channel: valid/ready request, variable-latency
// response (at most one outstanding, enforced by the requester).
//   req_valid  : requester -> memory, fetch request
//   req_addr   : requester -> memory, word-aligned address
//   req_ready  : memory -> requester, request accepted when valid && ready
//   resp_valid : memory -> requester, response data valid
//   resp_data  : memory -> requester, fetched instruction word
// Modports: master = fetch stage, slave = instruction memory.
// ---------------------------------------------------------------------------
interface if_stage_if;

    logic                       req_valid;
    logic [riscv_pkg::XLEN-1:0] req_addr;
    logic                       req_ready;
    logic                       resp_valid;
    logic [riscv_pkg::XLEN-1:0] resp_data;

    modport master (
        output req_valid, req_addr,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// ---------------------------------------------------------------------------
// fetch_skid_buf
// One-entry holding buffer for a fetch response that arrives while the
// IF/ID register is stalled.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_entry
//   drain      : entry has been moved downstream, mark empty
//   clear      : flush, mark empty (wins over load and drain)
//   load_entry : entry to capture
//   entry      : current buffer contents (entry.valid = occupied)
// ---------------------------------------------------------------------------
module fetch_skid_buf
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         drain,
    input  logic         clear,
    input  fetch_entry_t load_entry,
    output fetch_entry_t entry
);

    fetch_entry_t ent_q, ent_d;

    always_comb begin
        ent_d = ent_q;
        if (clear) begin
            ent_d.valid = 1'b0;
        end else if (load) begin
            ent_d = load_entry;
        end else if (drain) begin
            ent_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    assign entry = ent_q;

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction fetch stage: owns the PC, issues one-at-a-time word fetches,
// and holds the IF/ID register feeding id_stage.
//   clk, rst_n      : clock, asynchronous active-low reset
//   stall_in        : hold the IF/ID register
//   redirect_valid  : EX control transfer taken this cycle (flush)
//   redirect_pc     : redirect target, low two bits ignored
//   imem            : fetch channel (master side)
//   if_id_valid     : IF/ID holds a real instruction
//   if_id_instr     : instruction to id_stage (NOP_INSTR when bubble)
//   if_id_pc        : PC of if_id_instr
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_in,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    if_stage_if.master        imem,
    output logic              if_id_valid,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc
);

    import riscv_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    fetch_entry_t out_q, out_d;
    fetch_entry_t b_entry, resp_entry;
    logic         b_load, b_drain, b_clear;
    logic         req_fire, resp_wait;
    logic         unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign req_fire   = imem.req_valid && imem.req_ready;
    // Responses only count in WAIT; in DRAIN they belong to a killed fetch.
    assign resp_wait  = (state_q == WAIT) && imem.resp_valid;
    assign resp_entry = '{valid: 1'b1, instr: imem.resp_data, pc: req_pc_q};

    assign imem.req_addr = pc_q;

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            // The in-flight fetch (if any) is dead; if its response shows up
            // this very cycle there is nothing left to drain.
            case (state_q)
                WAIT, DRAIN: state_d = imem.resp_valid ? FETCH : DRAIN;
                default:     state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH:   state_d = req_fire ? WAIT : FETCH;
                WAIT:    if (imem.resp_valid) state_d = req_fire ? WAIT : FETCH;
                DRAIN:   if (imem.resp_valid) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    // ---- FSM: outputs ----
    // In WAIT the next request goes out in the same cycle the response is
    // consumed by the IF/ID register, which gives one fetch per cycle at k=1.
    always_comb begin
        imem.req_valid = 1'b0;
        if (rst_n && !redirect_valid) begin
            case (state_q)
                FETCH:   imem.req_valid = !b_entry.valid;
                WAIT:    imem.req_valid = imem.resp_valid && !stall_in;
                default: imem.req_valid = 1'b0;
            endcase
        end
    end

    // ---- PC, IF/ID register and buffer control ----
    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        out_d    = out_q;
        b_load   = 1'b0;
        b_drain  = 1'b0;
        b_clear  = 1'b0;

        if (req_fire) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
        end

        if (redirect_valid) begin
            pc_d        = {redirect_pc[31:2], 2'b00};
            out_d.valid = 1'b0;
            out_d.instr = NOP_INSTR;
            b_clear     = 1'b1;
        end else if (resp_wait && !stall_in) begin
            out_d = resp_entry;
        end else if (resp_wait) begin
            b_load = 1'b1;
        end else if (!stall_in) begin
            if (b_entry.valid) begin
                out_d   = b_entry;
                b_drain = 1'b1;
            end else begin
                out_d.valid = 1'b0;
                out_d.instr = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            out_q    <= '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0};
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            out_q    <= out_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (b_load),
        .drain      (b_drain),
        .clear      (b_clear),
        .load_entry (resp_entry),
        .entry      (b_entry)
    );

    assign if_id_valid = out_q.valid;
    assign if_id_instr = out_q.instr;
    assign if_id_pc    = out_q.pc;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
// Bench for if_stage. A behavioural instruction memory answers each accepted
// request after a fixed or random latency. Directed scenarios check exact
// cycle behaviour; the random scenario checks the stream of delivered
// instructions against the expected program order (sequential PCs, restarted
// at each redirect target) and that stalls hold the IF/ID register.
// Inputs change 1ns after the falling edge, checks happen 2ns after it, and
// the memory samples request handshakes 3ns after it.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_in = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;

    int checks = 0;
    int errors = 0;

    if_stage_if imem ();

    if_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc)
    );

    always #5 clk = ~clk;

    // ---- instruction memory model ----
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    int          cyc = 0;
    int          mem_resp_cyc = 0;
    int          mem_lat = 1;
    bit          mem_rand = 1'b0;
    bit          mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_viol = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) mem_pend = 1'b0;
        if (mem_pend && cyc == mem_resp_cyc) begin
            imem.resp_valid = 1'b1;
            imem.resp_data  = mem_word(mem_addr);
            mem_pend        = 1'b0;
        end else begin
            imem.resp_valid = 1'b0;
            imem.resp_data  = $urandom;
        end
        imem.req_ready = mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        #3;
        if (!rst_n) begin
            mem_pend        = 1'b0;
            imem.resp_valid = 1'b0;
        end else if (imem.req_valid && imem.req_ready) begin
            if (mem_pend) mem_viol++;
            mem_pend     = 1'b1;
            mem_addr     = imem.req_addr;
            mem_resp_cyc = cyc + (mem_rand ? int'($urandom_range(1, 3)) : mem_lat);
        end
    end

    function automatic logic [64:0] o_now();
        return {if_id_valid, if_id_instr, if_id_pc};
    endfunction

    function automatic logic [32:0] rq_now();
        return {imem.req_valid, imem.req_addr};
    endfunction

    // Advance to the drive point of the next cycle.
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    // Advance to the check point of the next cycle without changing inputs.
    task automatic step2();
        @(negedge clk);
        #2;
    endtask

    // Hold reset a few cycles, release it at the drive point of cycle A and
    // return at the check point of cycle A.
    task automatic do_reset();
        rst_n          = 1'b0;
        stall_in       = 1'b0;
        redirect_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        mem_rand = 1'b0; mem_lat = 1;
        rst_n = 1'b0; stall_in = 1'b0; redirect_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (o_now() !== {1'b0, NOP, 32'h0}) begin
            errors++; $display("FAIL reset_o got %h exp %h", o_now(), {1'b0, NOP, 32'h0});
        end
        checks++;
        if (imem.req_valid !== 1'b0) begin
            errors++; $display("FAIL reset_req got %b exp 0", imem.req_valid);
        end
    endtask

    task automatic test_fetch_seq();
        mem_rand = 1'b0; mem_lat = 1;
        do_reset();
        checks++;
        if (rq_now() !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL seq_req0 got %h exp %h", rq_now(), {1'b1, 32'h0});
        end
        step2();
        checks++;
        if (o_now() !== {1'b0, NOP, 32'h0} || rq_now() !== {1'b1, 32'h4}) begin
            errors++; $display("FAIL seq_c1 got o=%h rq=%h exp o=%h rq=%h", o_now(), rq_now(), {1'b0, NOP, 32'h0}, {1'b1, 32'h4});
        end
        for (int i = 0; i < 3; i++) begin
            step2();
            checks++;
            if (o_now() !== {1'b1, mem_word(32'(i * 4)), 32'(i * 4)}) begin
                errors++; $display("FAIL seq_o%0d got %h exp %h", i, o_now(), {1'b1, mem_word(32'(i * 4)), 32'(i * 4)});
            end
        end
    endtask

    task automatic test_stall();
        mem_rand = 1'b0; mem_lat = 1;
        do_reset();
        step2(); step2();
        // cycles A+3..A+5 stalled; response for 0x8 lands in the buffer
        for (int i = 0; i < 4; i++) begin
            nxt();
            stall_in = (i < 3);
            #1;
            checks++;
            if (o_now() !== {1'b1, mem_word(32'h4), 32'h4} || imem.req_valid !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d got o=%h req=%b exp o=%h req=0", i, o_now(), imem.req_valid, {1'b1, mem_word(32'h4), 32'h4});
            end
        end
        step2();
        checks++;
        if (o_now() !== {1'b1, mem_word(32'h8), 32'h8} || rq_now() !== {1'b1, 32'hC}) begin
            errors++; $display("FAIL stall_drain got o=%h rq=%h exp o=%h rq=%h", o_now(), rq_now(), {1'b1, mem_word(32'h8), 32'h8}, {1'b1, 32'hC});
        end
        step2();
        checks++;
        if (o_now() !== {1'b0, NOP, 32'h8}) begin
            errors++; $display("FAIL stall_bubble got %h exp %h", o_now(), {1'b0, NOP, 32'h8});
        end
        step2();
        checks++;
        if (o_now() !== {1'b1, mem_word(32'hC), 32'hC}) begin
            errors++; $display("FAIL stall_resume got %h exp %h", o_now(), {1'b1, mem_word(32'hC), 32'hC});
        end
    endtask

    task automatic test_redirect_wait();
        mem_rand = 1'b0; mem_lat = 3;
        do_reset();
        repeat (4) step2();
        checks++;
        if (o_now() !== {1'b1, mem_word(32'h0), 32'h0}) begin
            errors++; $display("FAIL rdw_o0 got %h exp %h", o_now(), {1'b1, mem_word(32'h0), 32'h0});
        end
        repeat (2) step2();
        nxt();  // A+7: waiting on 0x8, redirect to 0x100
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        checks++;
        if (o_now() !== {1'b1, mem_word(32'h4), 32'h4} || imem.req_valid !== 1'b0) begin
            errors++; $display("FAIL rdw_at got o=%h req=%b exp o=%h req=0", o_now(), imem.req_valid, {1'b1, mem_word(32'h4), 32'h4});
        end
        nxt();
        redirect_valid = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_now() !== {1'b0, NOP, 32'h4} || imem.req_valid !== 1'b0) begin
                errors++; $display("FAIL rdw_drain%0d got o=%h req=%b exp o=%h req=0", i, o_now(), imem.req_valid, {1'b0, NOP, 32'h4});
            end
            step2();
        end
        checks++;
        if (rq_now() !== {1'b1, 32'h100} || o_now() !== {1'b0, NOP, 32'h4}) begin
            errors++; $display("FAIL rdw_refetch got rq=%h o=%h exp rq=%h o=%h", rq_now(), o_now(), {1'b1, 32'h100}, {1'b0, NOP, 32'h4});
        end
        repeat (4) step2();
        checks++;
        if (o_now() !== {1'b1, mem_word(32'h100), 32'h100}) begin
            errors++; $display("FAIL rdw_target got %h exp %h", o_now(), {1'b1, mem_word(32'h100), 32'h100});
        end
    endtask

    task automatic test_redirect_stall();
        mem_rand = 1'b0; mem_lat = 1;
        do_reset();
        step2();
        nxt();  // A+2: response for 0x4 arrives with stall and redirect
        stall_in = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        checks++;
        if (imem.req_valid !== 1'b0) begin
            errors++; $display("FAIL rds_req got %b exp 0", imem.req_valid);
        end
        nxt();
        stall_in = 1'b0; redirect_valid = 1'b0;
        #1;
        checks++;
        if (o_now() !== {1'b0, NOP, 32'h0} || rq_now() !== {1'b1, 32'h100}) begin
            errors++; $display("FAIL rds_flush got o=%h rq=%h exp o=%h rq=%h", o_now(), rq_now(), {1'b0, NOP, 32'h0}, {1'b1, 32'h100});
        end
        step2();
        checks++;
        if (o_now() !== {1'b0, NOP, 32'h0}) begin
            errors++; $display("FAIL rds_bubble got %h exp %h", o_now(), {1'b0, NOP, 32'h0});
        end
        step2();
        checks++;
        if (o_now() !== {1'b1, mem_word(32'h100), 32'h100}) begin
            errors++; $display("FAIL rds_target got %h exp %h", o_now(), {1'b1, mem_word(32'h100), 32'h100});
        end
    endtask

    task automatic test_align_wrap();
        mem_rand = 1'b0; mem_lat = 1;
        do_reset();
        nxt();  // A+1: response for 0x0 killed by redirect
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        #1;
        checks++;
        if (imem.req_valid !== 1'b0) begin
            errors++; $display("FAIL aw_req got %b exp 0", imem.req_valid);
        end
        nxt();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (rq_now() !== {1'b1, 32'h200} || o_now() !== {1'b0, NOP, 32'h0}) begin
            errors++; $display("FAIL aw_align got rq=%h o=%h exp rq=%h o=%h", rq_now(), o_now(), {1'b1, 32'h200}, {1'b0, NOP, 32'h0});
        end
        nxt();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        #1;
        nxt();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (rq_now() !== {1'b1, 32'hFFFF_FFFC} || o_now() !== {1'b0, NOP, 32'h0}) begin
            errors++; $display("FAIL aw_top got rq=%h o=%h exp rq=%h o=%h", rq_now(), o_now(), {1'b1, 32'hFFFF_FFFC}, {1'b0, NOP, 32'h0});
        end
        step2();
        checks++;
        if (rq_now() !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL aw_wrap got %h exp %h", rq_now(), {1'b1, 32'h0});
        end
        step2();
        checks++;
        if (o_now() !== {1'b1, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC}) begin
            errors++; $display("FAIL aw_o_top got %h exp %h", o_now(), {1'b1, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC});
        end
        step2();
        checks++;
        if (o_now() !== {1'b1, mem_word(32'h0), 32'h0}) begin
            errors++; $display("FAIL aw_o_wrap got %h exp %h", o_now(), {1'b1, mem_word(32'h0), 32'h0});
        end
    endtask

    task automatic test_async_reset();
        mem_rand = 1'b0; mem_lat = 1;
        do_reset();
        step2(); step2();  // A+2: O holds 0x0, request for 0x8 going out
        checks++;
        if (o_now() !== {1'b1, mem_word(32'h0), 32'h0} || rq_now() !== {1'b1, 32'h8}) begin
            errors++; $display("FAIL ar_pre got o=%h rq=%h exp o=%h rq=%h", o_now(), rq_now(), {1'b1, mem_word(32'h0), 32'h0}, {1'b1, 32'h8});
        end
        #2;  // between clock edges
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_now() !== {1'b0, NOP, 32'h0} || imem.req_valid !== 1'b0) begin
            errors++; $display("FAIL ar_async got o=%h req=%b exp o=%h req=0", o_now(), imem.req_valid, {1'b0, NOP, 32'h0});
        end
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (rq_now() !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL ar_restart got %h exp %h", rq_now(), {1'b1, 32'h0});
        end
        step2(); step2();
        checks++;
        if (o_now() !== {1'b1, mem_word(32'h0), 32'h0}) begin
            errors++; $display("FAIL ar_first got %h exp %h", o_now(), {1'b1, mem_word(32'h0), 32'h0});
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [64:0] o, p_o;
        bit          p_stall, p_redir;
        int          nvalid, viol0;
        mem_rand = 1'b1;
        do_reset();
        exp_pc = 32'h0; p_stall = 1'b0; p_redir = 1'b0; nvalid = 0;
        viol0 = mem_viol;
        p_o = o_now();
        for (int n = 0; n < 600; n++) begin
            nxt();
            o = o_now();
            if (p_redir) begin
                checks++;
                if (o[64] !== 1'b0) begin
                    errors++; $display("FAIL rnd_flush cyc %0d got valid %b exp 0", n, o[64]);
                end
            end else if (p_stall) begin
                checks++;
                if (o !== p_o) begin
                    errors++; $display("FAIL rnd_hold cyc %0d got %h exp %h", n, o, p_o);
                end
            end else if (o[64]) begin
                checks++;
                if (o !== {1'b1, mem_word(exp_pc), exp_pc}) begin
                    errors++; $display("FAIL rnd_stream cyc %0d got %h exp %h", n, o, {1'b1, mem_word(exp_pc), exp_pc});
                end
                exp_pc = exp_pc + 32'd4;
                nvalid++;
            end
            p_o = o;
            stall_in       = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
            p_stall = stall_in;
            p_redir = redirect_valid;
            #1;
            checks++;
            if (imem.req_valid && (redirect_valid || imem.req_addr[1:0] != 2'b00)) begin
                errors++; $display("FAIL rnd_req cyc %0d got rq=%h redirect=%b exp no request or aligned", n, rq_now(), redirect_valid);
            end
        end
        stall_in = 1'b0; redirect_valid = 1'b0;
        checks++;
        if (nvalid < 60) begin
            errors++; $display("FAIL rnd_progress got %0d instructions exp at least 60", nvalid);
        end
        checks++;
        if (mem_viol !== viol0) begin
            errors++; $display("FAIL rnd_outstanding got %0d overlapping requests exp 0", mem_viol - viol0);
        end
        mem_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_seq();
        test_stall();
        test_redirect_wait();
        test_redirect_stall();
        test_align_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
